// File: rtl/hit_pkg.sv
// Shared event types for the collision dispatcher: event kind enum, packed event record
// and a lowest-set-bit helper used to name the ball in single-ball events.
package hit_pkg;

  localparam int MAX_BALLS = 16;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    HOLE = 2'd1,
    BALL = 2'd2,
    WALL = 2'd3
  } evt_type_e;

  typedef struct packed {
    evt_type_e  etype;
    logic [3:0] ball_a;
    logic [3:0] ball_b;
    logic [1:0] wall;
  } evt_t;

  function automatic logic [3:0] lowest_bit(input logic [MAX_BALLS-1:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_BALLS - 1; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Show-ahead event queue: head is the oldest entry, valid whenever empty is low.
module event_fifo
  import hit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output evt_t head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  evt_t          mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

endmodule

// File: rtl/collision_dispatcher.sv
// Collects hole/ball/wall collision pulses into one pending slot per source and
// serialises them into an event queue with fixed priority HOLE > BALL > WALL.
module collision_dispatcher
  import hit_pkg::*;
#(
  parameter int BALL_VEC_W = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic [BALL_VEC_W-1:0] ballhole_collide,
  input  logic [BALL_VEC_W-1:0] balls_collide,
  input  logic [1:0][3:0]       Balls_col_ID,
  input  logic [BALL_VEC_W-1:0] ballwall_collide,
  input  logic [1:0]            collided_wall,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [1:0]            evt_type,
  output logic [3:0]            evt_ballA,
  output logic [3:0]            evt_ballB,
  output logic [1:0]            evt_wall,
  output logic [7:0]            drop_count,
  output logic [3:0]            frame_events
);

  logic hole_in, ball_in, wall_in;
  logic hole_v, ball_v, wall_v;
  evt_t hole_e, ball_e, wall_e;
  evt_t hole_new, ball_new, wall_new;
  logic push_hole, push_ball, push_wall, push, pop, can_push;
  logic drop_hole, drop_ball, drop_wall;
  evt_t push_data, head, evt_out;
  logic full, empty;
  logic [1:0] n_drop;
  logic [8:0] drop_sum;
  logic [3:0] frame_cnt;
  logic [3:0] frame_inc;

  assign hole_in = |ballhole_collide;
  assign ball_in = |balls_collide;
  assign wall_in = |ballwall_collide;

  assign hole_new = '{etype: HOLE, ball_a: lowest_bit(MAX_BALLS'(ballhole_collide)),
                      ball_b: 4'd0, wall: 2'd0};
  assign ball_new = '{etype: BALL, ball_a: Balls_col_ID[0], ball_b: Balls_col_ID[1],
                      wall: 2'd0};
  assign wall_new = '{etype: WALL, ball_a: lowest_bit(MAX_BALLS'(ballwall_collide)),
                      ball_b: 4'd0, wall: collided_wall};

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop      = evt_valid && evt_ready;
  assign can_push = !full || pop;

  always_comb begin
    push_hole = can_push && hole_v;
    push_ball = can_push && !hole_v && ball_v;
    push_wall = can_push && !hole_v && !ball_v && wall_v;
    push      = push_hole || push_ball || push_wall;
    push_data = push_hole ? hole_e : (push_ball ? ball_e : wall_e);
    drop_hole = hole_in && hole_v && !push_hole;
    drop_ball = ball_in && ball_v && !push_ball;
    drop_wall = wall_in && wall_v && !push_wall;
    n_drop    = {1'b0, drop_hole} + {1'b0, drop_ball} + {1'b0, drop_wall};
    drop_sum  = {1'b0, drop_count} + {7'd0, n_drop};
    frame_inc = (frame_cnt == 4'hF) ? 4'hF : frame_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hole_v <= 1'b0;
      ball_v <= 1'b0;
      wall_v <= 1'b0;
      hole_e <= '0;
      ball_e <= '0;
      wall_e <= '0;
    end else begin
      if (hole_in && (!hole_v || push_hole)) begin
        hole_v <= 1'b1;
        hole_e <= hole_new;
      end else if (push_hole) begin
        hole_v <= 1'b0;
      end
      if (ball_in && (!ball_v || push_ball)) begin
        ball_v <= 1'b1;
        ball_e <= ball_new;
      end else if (push_ball) begin
        ball_v <= 1'b0;
      end
      if (wall_in && (!wall_v || push_wall)) begin
        wall_v <= 1'b1;
        wall_e <= wall_new;
      end else if (push_wall) begin
        wall_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drop_count   <= '0;
      frame_cnt    <= '0;
      frame_events <= '0;
    end else begin
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (startOfFrame) begin
        frame_events <= frame_cnt;
        frame_cnt    <= push ? 4'd1 : 4'd0;
      end else if (push) begin
        frame_cnt <= frame_inc;
      end
    end
  end

  event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .resetN    (resetN),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign evt_valid = !empty;
  assign evt_out   = evt_valid ? head : '0;
  assign evt_type  = evt_out.etype;
  assign evt_ballA = evt_out.ball_a;
  assign evt_ballB = evt_out.ball_b;
  assign evt_wall  = evt_out.wall;

endmodule

// File: tb/tb_collision_dispatcher.sv
// Directed bench for collision_dispatcher with a queue-based reference model checked every cycle.
module tb_collision_dispatcher;

  localparam int W = 3;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           resetN = 1'b0;
  logic           startOfFrame = 1'b0;
  logic [W-1:0]   ballhole_collide = '0;
  logic [W-1:0]   balls_collide = '0;
  logic [1:0][3:0] Balls_col_ID = '0;
  logic [W-1:0]   ballwall_collide = '0;
  logic [1:0]     collided_wall = '0;
  logic           evt_ready = 1'b0;
  logic           evt_valid;
  logic [1:0]     evt_type;
  logic [3:0]     evt_ballA, evt_ballB;
  logic [1:0]     evt_wall;
  logic [7:0]     drop_count;
  logic [3:0]     frame_events;

  collision_dispatcher #(.BALL_VEC_W(W), .FIFO_DEPTH(D)) dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .ballhole_collide (ballhole_collide),
    .balls_collide    (balls_collide),
    .Balls_col_ID     (Balls_col_ID),
    .ballwall_collide (ballwall_collide),
    .collided_wall    (collided_wall),
    .evt_valid        (evt_valid),
    .evt_ready        (evt_ready),
    .evt_type         (evt_type),
    .evt_ballA        (evt_ballA),
    .evt_ballB        (evt_ballB),
    .evt_wall         (evt_wall),
    .drop_count       (drop_count),
    .frame_events     (frame_events)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending event per source, the queue as a plain SV queue.
  typedef struct {int t; int a; int b; int w;} mev_t;
  mev_t m_q[$];
  mev_t m_pend[3];
  bit   m_has[3];
  mev_t m_arr[3];
  bit   m_pres[3];
  bit   m_pop, m_pushed;
  int   m_drop = 0;
  int   m_frame_cnt = 0;
  int   m_frame_ev = 0;

  function automatic int low_bit(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_q.delete();
      for (int i = 0; i < 3; i++) m_has[i] = 1'b0;
      m_drop = 0;
      m_frame_cnt = 0;
      m_frame_ev = 0;
    end else begin
      m_pop = (m_q.size() > 0) && evt_ready;
      m_pushed = 1'b0;
      if (m_pop) void'(m_q.pop_front());
      if (m_q.size() < D) begin
        for (int i = 0; i < 3; i++) begin
          if (m_has[i] && !m_pushed) begin
            m_q.push_back(m_pend[i]);
            m_has[i] = 1'b0;
            m_pushed = 1'b1;
          end
        end
      end
      m_arr[0] = '{1, low_bit(ballhole_collide), 0, 0};
      m_arr[1] = '{2, int'(Balls_col_ID[0]), int'(Balls_col_ID[1]), 0};
      m_arr[2] = '{3, low_bit(ballwall_collide), 0, int'(collided_wall)};
      m_pres[0] = ballhole_collide != 0;
      m_pres[1] = balls_collide != 0;
      m_pres[2] = ballwall_collide != 0;
      for (int i = 0; i < 3; i++) begin
        if (m_pres[i]) begin
          if (m_has[i]) begin
            if (m_drop < 255) m_drop++;
          end else begin
            m_pend[i] = m_arr[i];
            m_has[i] = 1'b1;
          end
        end
      end
      if (startOfFrame) begin
        m_frame_ev = m_frame_cnt;
        m_frame_cnt = m_pushed ? 1 : 0;
      end else if (m_pushed && m_frame_cnt < 15) begin
        m_frame_cnt++;
      end
    end
  end

  mev_t c_head;
  always @(negedge clk) begin
    c_head = (m_q.size() > 0) ? m_q[0] : '{0, 0, 0, 0};
    check("valid", int'(evt_valid), (m_q.size() > 0) ? 1 : 0);
    check("type", int'(evt_type), c_head.t);
    check("ballA", int'(evt_ballA), c_head.a);
    check("ballB", int'(evt_ballB), c_head.b);
    check("wall", int'(evt_wall), c_head.w);
    check("drop_count", int'(drop_count), m_drop);
    check("frame_events", int'(frame_events), m_frame_ev);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [W-1:0] h, input logic [W-1:0] b, input logic [W-1:0] w,
                       input logic [3:0] ia, input logic [3:0] ib, input logic [1:0] wc);
    ballhole_collide = h;
    balls_collide = b;
    ballwall_collide = w;
    Balls_col_ID[0] = ia;
    Balls_col_ID[1] = ib;
    collided_wall = wc;
    tick();
    ballhole_collide = '0;
    balls_collide = '0;
    ballwall_collide = '0;
    Balls_col_ID = '0;
    collided_wall = '0;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  logic [W-1:0] one_hot;
  int pops;
  int seen;

  initial begin
    one_hot = 1;
    #12;
    check("reset_valid", int'(evt_valid), 0);
    check("reset_drop", int'(drop_count), 0);
    check("reset_frame", int'(frame_events), 0);
    @(posedge clk);
    #2;
    resetN = 1'b1;
    tick();

    // single wall event, two-edge latency
    evt_ready = 1'b1;
    drive('0, '0, 3'b010, 4'd0, 4'd0, 2'd2);
    tick();
    check("wall_valid", int'(evt_valid), 1);
    check("wall_type", int'(evt_type), 3);
    check("wall_ballA", int'(evt_ballA), 1);
    check("wall_code", int'(evt_wall), 2);
    tick();
    check("wall_one_cycle", int'(evt_valid), 0);

    // simultaneous sources emerge in priority order
    drive(3'b100, 3'b011, 3'b001, 4'd0, 4'd1, 2'd1);
    tick();
    check("prio0_type", int'(evt_type), 1);
    check("prio0_ballA", int'(evt_ballA), 2);
    tick();
    check("prio1_type", int'(evt_type), 2);
    check("prio1_ballA", int'(evt_ballA), 0);
    check("prio1_ballB", int'(evt_ballB), 1);
    tick();
    check("prio2_type", int'(evt_type), 3);
    check("prio2_ballA", int'(evt_ballA), 0);
    check("prio2_wall", int'(evt_wall), 1);
    check("prio_drop", int'(drop_count), 0);
    tick();
    check("prio_idle", int'(evt_valid), 0);

    // back-pressure: 4 queued, 1 pending, 1 dropped
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive('0, '0, one_hot << ((i + 1) % 3), 4'd0, 4'd0, 2'((i + 1) % 4));
      tick();
    end
    check("bp_drop", int'(drop_count), 1);
    check("bp_head_type", int'(evt_type), 3);
    check("bp_head_ballA", int'(evt_ballA), 1);
    check("bp_head_wall", int'(evt_wall), 1);
    evt_ready = 1'b1;
    pops = 0;
    repeat (10) begin
      if (evt_valid) pops++;
      tick();
    end
    check("bp_drain_count", pops, 5);

    // two ball pulses back-to-back into a full queue
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(one_hot << (i % 3), '0, '0, 4'd0, 4'd0, 2'd0);
      tick();
    end
    drive('0, 3'b110, '0, 4'd1, 4'd2, 2'd0);
    drive('0, 3'b101, '0, 4'd0, 4'd2, 2'd0);
    tick();
    check("full_drop", int'(drop_count), 2);
    evt_ready = 1'b1;
    repeat (8) tick();
    check("full_drained", int'(evt_valid), 0);

    // frame counting
    sof_pulse();
    repeat (3) begin
      drive('0, '0, 3'b001, 4'd0, 4'd0, 2'd0);
      tick();
    end
    repeat (3) tick();
    sof_pulse();
    check("frame_3", int'(frame_events), 3);
    repeat (20) drive('0, '0, 3'b100, 4'd0, 4'd0, 2'd3);
    repeat (4) tick();
    sof_pulse();
    check("frame_sat", int'(frame_events), 15);
    check("frame_no_drop", int'(drop_count), 2);

    // reset with events queued
    evt_ready = 1'b0;
    drive(3'b010, 3'b011, 3'b100, 4'd2, 4'd3, 2'd2);
    repeat (4) tick();
    check("pre_reset_valid", int'(evt_valid), 1);
    #1 resetN = 1'b0;
    #1;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_type", int'(evt_type), 0);
    check("rst_drop", int'(drop_count), 0);
    check("rst_frame", int'(frame_events), 0);
    @(posedge clk);
    #2;
    resetN = 1'b1;
    evt_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      tick();
      if (evt_valid) seen++;
    end
    check("post_reset_events", seen, 0);
    sof_pulse();
    check("post_reset_frame", int'(frame_events), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
